button_debounce: RTL and testbench

- Input-side counterpart of the LED blinker: samples a raw, bouncing push-button pin on the 12 MHz board clock.
- Synchronises the pin and debounces it with a counter-driven FSM.
- Emits a clean level, single-cycle press/release/long-press event pulses, and a wrapping press counter for downstream logic and LED feedback.

---
 rtl/board_io_pkg.sv | 19 +
 rtl/sync_2ff.sv | 24 ++
 rtl/button_debounce.sv | 146 ++++++++++++++
 tb/tb_button_debounce.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_io_pkg.sv
// Shared types and board timing constants for 12 MHz board I/O blocks.
package board_io_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int DEBOUNCE_20MS_12MHZ = 240000;
  localparam int LONG_1S_12MHZ       = 12000000;

  // Bits needed for a counter that must reach max_count.
  function automatic int cnt_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchroniser for asynchronous board inputs; resets to 0.
module sync_2ff (
  input  logic clk_12mhz,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/button_debounce.sv
// Push-button synchroniser + debounce FSM with press/release/long-press pulses.
// Long-press detection is built only when BUTTON_DEBOUNCE_LONG_PRESS_EN is defined.
module button_debounce
  import board_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_12MHZ,
  parameter int LONG_CYCLES     = LONG_1S_12MHZ
) (
  input  logic       clk_12mhz,
  input  logic       rst_n,
  input  logic       btn_raw,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [7:0] press_count
);

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam int CNT_W = cnt_width(LONG_CYCLES);
`else
  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
`endif

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  generate
    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_params
      $error("button_debounce: need DEBOUNCE_CYCLES >= 2 and LONG_CYCLES > DEBOUNCE_CYCLES");
    end
  endgenerate

  logic             w_btn_sync;
  btn_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;
  logic             r_release;
  logic [7:0]       r_count;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  logic             r_long;
  logic             r_long_fired;
`endif

  sync_2ff u_sync (
    .clk_12mhz (clk_12mhz),
    .rst_n     (rst_n),
    .i_async   (btn_raw),
    .o_sync    (w_btn_sync)
  );

  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_count   <= 8'h00;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
      r_long       <= 1'b0;
      r_long_fired <= 1'b0;
`endif
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
      r_long    <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_btn_sync) begin
            r_state <= PRESS_WAIT;
            r_cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!w_btn_sync) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == DEB_LAST) begin
            r_state <= PRESSED;
            r_level <= 1'b1;
            r_press <= 1'b1;
            r_count <= r_count + 8'd1;
            r_cnt   <= '0;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
            r_long_fired <= 1'b0;
`endif
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!w_btn_sync) begin
            r_state <= RELEASE_WAIT;
            r_cnt   <= '0;
          end else begin
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
            // Counter parks at LONG_LAST once fired so only one pulse per press.
            if (!r_long_fired) begin
              if (r_cnt == LONG_LAST) begin
                r_long       <= 1'b1;
                r_long_fired <= 1'b1;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
`else
            r_cnt <= '0;
`endif
          end
        end
        RELEASE_WAIT: begin
          if (w_btn_sync) begin
            r_state <= PRESSED;
            r_cnt   <= '0;
          end else if (r_cnt == DEB_LAST) begin
            r_state   <= IDLE;
            r_level   <= 1'b0;
            r_release <= 1'b1;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign btn_level     = r_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign press_count   = r_count;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  assign long_pulse    = r_long;
`else
  assign long_pulse    = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Randomised scoreboard bench for button_debounce (DEBOUNCE_CYCLES=4, LONG_CYCLES=16).
module tb_button_debounce;

  localparam int D = 4;
  localparam int L = 16;
  localparam int K_PRESS = 0, K_RELEASE = 1, K_LONG = 2;

  logic       clk_12mhz = 1'b0;
  logic       rst_n     = 1'b0;
  logic       btn_raw   = 1'b0;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [7:0] press_count;

  button_debounce #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
    .clk_12mhz     (clk_12mhz),
    .rst_n         (rst_n),
    .btn_raw       (btn_raw),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .press_count   (press_count)
  );

  always #5 clk_12mhz = ~clk_12mhz;

  typedef struct {
    int kind;
    int cyc;
    int cnt;
    int lvl;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  int  n_press_seen = 0, n_release_seen = 0, n_long_seen = 0;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  // Reference model: a level change is accepted once the synchronised input has
  // disagreed with the accepted level for D+1 consecutive samples; a long press
  // is L consecutive held samples after the sample that (re)entered the pressed level.
  int m_h1, m_h2, m_level, m_run, m_hold, m_prev, m_count;
  bit m_fired;

  always @(posedge clk_12mhz) begin
    int  s;
    bit  accepted;
    cyc = cyc + 1;
    if (!rst_n) begin
      m_h1 = 0; m_h2 = 0; m_level = 0; m_run = 0; m_hold = 0;
      m_prev = 0; m_count = 0; m_fired = 0;
    end else begin
      s        = m_h2;
      m_h2     = m_h1;
      m_h1     = int'(btn_raw);
      accepted = 1'b0;
      if (s != m_level) begin
        m_run = m_run + 1;
        if (m_run == D + 1) begin
          accepted = 1'b1;
          m_level  = s;
          m_run    = 0;
          if (s == 1) begin
            m_count = (m_count + 1) % 256;
            m_hold  = 0;
            m_fired = 0;
            exp_q.push_back('{kind: K_PRESS, cyc: cyc, cnt: m_count, lvl: 1});
          end else begin
            exp_q.push_back('{kind: K_RELEASE, cyc: cyc, cnt: m_count, lvl: 0});
          end
        end
      end else begin
        m_run = 0;
      end
      if (!accepted && m_level == 1) begin
        if (s == 1 && m_prev == 1) m_hold = m_hold + 1;
        else                       m_hold = 0;
        if (LONG_EN && m_hold == L && !m_fired) begin
          m_fired = 1;
          exp_q.push_back('{kind: K_LONG, cyc: cyc, cnt: m_count, lvl: 1});
        end
      end
      m_prev = s;
    end
  end

  // Monitor: pops one expected event for every pulse the DUT presents.
  always @(negedge clk_12mhz) begin
    ev_t e;
    int  kind;
    if (rst_n) begin
      if (int'(press_pulse) + int'(release_pulse) + int'(long_pulse) > 1) begin
        n_tests = n_tests + 1;
        n_fail  = n_fail + 1;
        $display("FAIL multi_pulse cyc=%0d actual p/r/l=%b%b%b required at most one",
                 cyc, press_pulse, release_pulse, long_pulse);
      end
      if (press_pulse || release_pulse || long_pulse) begin
        kind = press_pulse ? K_PRESS : (release_pulse ? K_RELEASE : K_LONG);
        if (kind == K_PRESS)   n_press_seen   = n_press_seen + 1;
        if (kind == K_RELEASE) n_release_seen = n_release_seen + 1;
        if (kind == K_LONG)    n_long_seen    = n_long_seen + 1;
        n_tests = n_tests + 1;
        if (exp_q.size() == 0) begin
          n_fail = n_fail + 1;
          $display("FAIL unexpected_pulse cyc=%0d actual kind=%0d required none", cyc, kind);
        end else begin
          e = exp_q.pop_front();
          if (e.kind != kind || e.cyc != cyc || e.cnt != int'(press_count) ||
              e.lvl != int'(btn_level)) begin
            n_fail = n_fail + 1;
            $display("FAIL event actual kind=%0d cyc=%0d count=%0d level=%0d required kind=%0d cyc=%0d count=%0d level=%0d",
                     kind, cyc, press_count, btn_level, e.kind, e.cyc, e.cnt, e.lvl);
          end
        end
      end
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        n_tests = n_tests + 1;
        n_fail  = n_fail + 1;
        $display("FAIL missed_event actual none required kind=%0d at cyc=%0d", e.kind, e.cyc);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests = n_tests + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_12mhz);
  endtask

  task automatic hold(input logic v, input int n);
    btn_raw = v;
    tick(n);
  endtask

  // From the negedge before edge 0, expect the pulse exactly after edge `at`.
  task automatic expect_pulse_at(input string name, input int which, input int at);
    int v;
    for (int k = 0; k <= at + 1; k++) begin
      @(posedge clk_12mhz);
      #1;
      v = (which == K_PRESS) ? int'(press_pulse) : int'(release_pulse);
      check($sformatf("%s_edge%0d", name, k), v, (k == at) ? 1 : 0);
    end
    @(negedge clk_12mhz);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk_12mhz);
    rst_n = 1'b0;
    tick(n);
    rst_n = 1'b1;
  endtask

  initial begin
    int p0, r0, l0, c0;
    int lvl, len;

    btn_raw = 1'b0;
    rst_n   = 1'b0;
    tick(3);
    check("reset_level",   int'(btn_level), 0);
    check("reset_press",   int'(press_pulse), 0);
    check("reset_release", int'(release_pulse), 0);
    check("reset_long",    int'(long_pulse), 0);
    check("reset_count",   int'(press_count), 0);
    rst_n = 1'b1;
    tick(2);

    // Clean press
    btn_raw = 1'b1;
    expect_pulse_at("clean_press", K_PRESS, D + 2);
    check("clean_level", int'(btn_level), 1);
    check("clean_count", int'(press_count), 1);
    hold(1'b0, 12);
    check("clean_release_level", int'(btn_level), 0);

    // Bounce rejection
    p0 = n_press_seen;
    for (int i = 0; i < 8; i++) hold(((i % 2) == 0) ? 1'b1 : 1'b0, 1);
    hold(1'b0, 12);
    check("bounce_no_press", n_press_seen - p0, 0);
    check("bounce_level", int'(btn_level), 0);
    check("bounce_count", int'(press_count), 1);

    // Release with bounce
    hold(1'b1, 10);
    r0 = n_release_seen;
    hold(1'b0, 2);
    hold(1'b1, 1);
    btn_raw = 1'b0;
    expect_pulse_at("bounced_release", K_RELEASE, D + 2);
    tick(10);
    check("bounced_release_once", n_release_seen - r0, 1);
    check("bounced_release_level", int'(btn_level), 0);

    // Long press
    l0 = n_long_seen;
    hold(1'b1, 40);
    hold(1'b0, 12);
    check("long_count", n_long_seen - l0, LONG_EN ? 1 : 0);

    // Wrap: 256 clean press/release pairs from a fresh reset
    do_reset(2);
    p0 = n_press_seen;
    r0 = n_release_seen;
    for (int i = 0; i < 256; i++) begin
      hold(1'b1, 8);
      hold(1'b0, 8);
    end
    check("wrap_count", int'(press_count), 0);
    check("wrap_presses", n_press_seen - p0, 256);
    check("wrap_releases", n_release_seen - r0, 256);

    // Reset mid PRESS_WAIT with a non-zero press count
    hold(1'b1, 10);
    hold(1'b0, 10);
    check("pre_reset_count", int'(press_count), 1);
    btn_raw = 1'b1;
    tick(5);             // edges 0..4: FSM now in PRESS_WAIT with cnt=2
    rst_n = 1'b0;
    #1;
    check("midreset_level", int'(btn_level), 0);
    check("midreset_press", int'(press_pulse), 0);
    check("midreset_count", int'(press_count), 0);
    check("midreset_long",  int'(long_pulse), 0);
    tick(2);
    rst_n = 1'b1;
    expect_pulse_at("post_reset_press", K_PRESS, D + 2);
    check("post_reset_count", int'(press_count), 1);
    hold(1'b0, 12);

    // Randomised bouncing traffic against the reference model
    for (int seg = 0; seg < 300; seg++) begin
      lvl = int'($urandom_range(0, 1));
      len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(18, 30))
                                        : int'($urandom_range(1, 2 * D + 2));
      hold(lvl[0], len);
    end
    hold(1'b0, 15);
    c0 = m_count;
    check("rand_final_level", int'(btn_level), m_level);
    check("rand_final_count", int'(press_count), c0);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
